branch_target_table: RTL and testbench



---
 rtl/branch_target_table.sv | 126 ++++++++++++
 tb/tb_branch_target_table.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_table.sv
// Writable branch-target lookup table: DEPTH entries of {valid, target}, swept clear
// after reset/Clear, with a registered one-cycle lookup and write-first bypass.
module branch_target_table #(
    parameter int ADDR_W = 4,
    parameter int TGT_W  = 10,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clear,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [TGT_W-1:0]  WrData,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic              Ready,
    output logic              RdValid,
    output logic [TGT_W-1:0]  Target,
    output logic              Hit
);

    typedef enum logic {INIT, RUN} state_e;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [TGT_W-1:0]    mem_q [DEPTH];
    logic                vld_q [DEPTH];
    logic                rdvalid_q, hit_q, hit_d;
    logic [TGT_W-1:0]    tgt_q, tgt_d;

    logic                in_run, wr_fire, rd_fire, byp;
    logic                rd_vld;
    logic [TGT_W-1:0]    rd_data;

    assign in_run  = (state_q == RUN);
    assign wr_fire = in_run && !Reset && !Clear && WrEn && ({1'b0, WrAddr} < DEPTH_W);
    assign rd_fire = in_run && !Reset && !Clear && RdEn;
    assign byp     = wr_fire && (WrAddr == RdAddr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (Clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (Clear) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // No reset on storage: the INIT sweep is what clears it.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!in_run && cnt_q == ADDR_W'(i)) begin
                vld_q[i] <= 1'b0;
                mem_q[i] <= '0;
            end else if (wr_fire && WrAddr == ADDR_W'(i)) begin
                vld_q[i] <= 1'b1;
                mem_q[i] <= WrData;
            end
        end
    end

    // Mux-by-compare keeps out-of-range indices a natural miss.
    always_comb begin
        rd_vld  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RdAddr == ADDR_W'(i)) begin
                rd_vld  = vld_q[i];
                rd_data = mem_q[i];
            end
        end
        hit_d = byp || rd_vld;
        tgt_d = byp ? WrData : (rd_vld ? rd_data : '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdvalid_q <= 1'b0;
            hit_q     <= 1'b0;
            tgt_q     <= '0;
        end else begin
            rdvalid_q <= rd_fire;
            if (rd_fire) begin
                hit_q <= hit_d;
                tgt_q <= tgt_d;
            end
        end
    end

    assign Ready   = in_run;
    assign RdValid = rdvalid_q;
    assign Hit     = hit_q;
    assign Target  = tgt_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench: a DEPTH=16 table for sweep/bypass/clear/reset cases and a
// DEPTH=10 table for out-of-range handling.
module tb_branch_target_table;

    logic       Clk = 1'b0;
    logic       Reset, Clear, WrEn, RdEn;
    logic [3:0] WrAddr, RdAddr;
    logic [9:0] WrData;
    logic       Ready, RdValid, Hit;
    logic [9:0] Target;

    logic       b_clear, b_wren, b_rden;
    logic [3:0] b_waddr, b_raddr;
    logic [9:0] b_wdata;
    logic       b_ready, b_rdvalid, b_hit;
    logic [9:0] b_target;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    branch_target_table #(.ADDR_W(4), .TGT_W(10), .DEPTH(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .RdEn(RdEn), .RdAddr(RdAddr), .Ready(Ready),
        .RdValid(RdValid), .Target(Target), .Hit(Hit)
    );

    branch_target_table #(.ADDR_W(4), .TGT_W(10), .DEPTH(10)) dut_b (
        .Clk(Clk), .Reset(Reset), .Clear(b_clear), .WrEn(b_wren), .WrAddr(b_waddr),
        .WrData(b_wdata), .RdEn(b_rden), .RdAddr(b_raddr), .Ready(b_ready),
        .RdValid(b_rdvalid), .Target(b_target), .Hit(b_hit)
    );

    typedef struct {
        logic       clr;
        logic       wr;
        logic [3:0] waddr;
        logic [9:0] wdata;
        logic       rd;
        logic [3:0] raddr;
        logic       e_ready;
        logic       e_valid;
        logic       e_hit;
        logic [9:0] e_tgt;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_a();
        Clear = 0; WrEn = 0; RdEn = 0; WrAddr = 0; RdAddr = 0; WrData = 0;
    endtask

    task automatic count_init(input int exp_cycles, input string name);
        int n = 0;
        while (!Ready && n < 40) begin
            n++;
            step();
        end
        chk(name, n, exp_cycles);
    endtask

    task automatic read_all_miss_a(input string name);
        for (int i = 0; i < 16; i++) begin
            RdEn = 1; RdAddr = 4'(i);
            step();
            chk({name, " valid"}, RdValid, 1);
            chk({name, " hit"}, Hit, 0);
            chk({name, " tgt"}, Target, 0);
        end
        RdEn = 0;
    endtask

    function automatic vec_t mk(logic clr, logic wr, logic [3:0] wa, logic [9:0] wd,
                                logic rd, logic [3:0] ra, logic er, logic ev,
                                logic eh, logic [9:0] et);
        vec_t v;
        v.clr = clr; v.wr = wr; v.waddr = wa; v.wdata = wd; v.rd = rd; v.raddr = ra;
        v.e_ready = er; v.e_valid = ev; v.e_hit = eh; v.e_tgt = et;
        return v;
    endfunction

    initial begin
        int n_a, n_b;

        //              clr wr wa  wdata    rd ra  rdy vld hit tgt
        vecs[0]  = mk(0, 1, 3, 10'h2A5, 0, 0, 1, 0, 0, 10'h000);
        vecs[1]  = mk(0, 0, 0, 10'h000, 1, 3, 1, 1, 1, 10'h2A5);
        vecs[2]  = mk(0, 0, 0, 10'h000, 1, 4, 1, 1, 0, 10'h000);
        vecs[3]  = mk(0, 0, 0, 10'h000, 0, 0, 1, 0, 0, 10'h000);
        vecs[4]  = mk(0, 1, 7, 10'h155, 1, 7, 1, 1, 1, 10'h155);
        vecs[5]  = mk(0, 0, 0, 10'h000, 0, 0, 1, 0, 1, 10'h155);
        vecs[6]  = mk(0, 1, 0, 10'h011, 0, 0, 1, 0, 1, 10'h155);
        vecs[7]  = mk(0, 1, 1, 10'h022, 0, 0, 1, 0, 1, 10'h155);
        vecs[8]  = mk(0, 1, 2, 10'h033, 0, 0, 1, 0, 1, 10'h155);
        vecs[9]  = mk(0, 0, 0, 10'h000, 1, 0, 1, 1, 1, 10'h011);
        vecs[10] = mk(0, 0, 0, 10'h000, 1, 1, 1, 1, 1, 10'h022);
        vecs[11] = mk(0, 0, 0, 10'h000, 1, 2, 1, 1, 1, 10'h033);
        vecs[12] = mk(0, 0, 0, 10'h000, 1, 3, 1, 1, 1, 10'h2A5);
        vecs[13] = mk(0, 1, 5, 10'h0AA, 1, 6, 1, 1, 0, 10'h000);
        vecs[14] = mk(0, 0, 0, 10'h000, 1, 5, 1, 1, 1, 10'h0AA);
        vecs[15] = mk(0, 1, 15, 10'h3C3, 1, 7, 1, 1, 1, 10'h155);
        vecs[16] = mk(0, 0, 0, 10'h000, 1, 15, 1, 1, 1, 10'h3C3);
        vecs[17] = mk(1, 1, 1, 10'h0F0, 1, 1, 0, 0, 1, 10'h3C3);

        idle_a();
        b_clear = 0; b_wren = 0; b_rden = 0; b_waddr = 0; b_raddr = 0; b_wdata = 0;

        Reset = 1;
        step();
        chk("reset ready", Ready, 0);
        chk("reset rdvalid", RdValid, 0);
        chk("reset target", Target, 0);
        chk("reset hit", Hit, 0);
        chk("reset b ready", b_ready, 0);
        Reset = 0;

        n_a = 0; n_b = 0;
        while (!Ready && n_a < 40) begin
            n_a++;
            if (!b_ready) n_b++;
            step();
        end
        chk("init len a", n_a, 16);
        chk("init len b", n_b, 10);

        read_all_miss_a("sweep miss");

        for (int i = 0; i < 18; i++) begin
            Clear = vecs[i].clr; WrEn = vecs[i].wr; WrAddr = vecs[i].waddr;
            WrData = vecs[i].wdata; RdEn = vecs[i].rd; RdAddr = vecs[i].raddr;
            step();
            chk($sformatf("vec%0d ready", i), Ready, vecs[i].e_ready);
            chk($sformatf("vec%0d valid", i), RdValid, vecs[i].e_valid);
            chk($sformatf("vec%0d hit", i), Hit, vecs[i].e_hit);
            chk($sformatf("vec%0d tgt", i), Target, vecs[i].e_tgt);
        end
        idle_a();

        // Clear was taken in vec17; Ready already low for one cycle.
        count_init(16, "clear init len");
        read_all_miss_a("post-clear miss");

        // Out-of-range on the 10-entry table.
        b_wren = 1; b_waddr = 12; b_wdata = 10'h3FF;
        step();
        b_wren = 0;
        chk("oor write no resp", b_rdvalid, 0);
        b_rden = 1; b_raddr = 12;
        step();
        chk("oor rd valid", b_rdvalid, 1);
        chk("oor rd hit", b_hit, 0);
        chk("oor rd tgt", b_target, 0);
        for (int i = 0; i < 10; i++) begin
            b_raddr = 4'(i);
            step();
            chk($sformatf("b untouched %0d hit", i), b_hit, 0);
            chk($sformatf("b untouched %0d tgt", i), b_target, 0);
        end
        b_rden = 0; b_wren = 1; b_waddr = 9; b_wdata = 10'h123;
        step();
        b_wren = 0; b_rden = 1; b_raddr = 9;
        step();
        chk("b last entry hit", b_hit, 1);
        chk("b last entry tgt", b_target, 10'h123);
        b_rden = 0;

        // Requests during INIT are ignored; Reset in INIT cycle 5 restarts the sweep.
        Clear = 1;
        step();
        Clear = 0;
        chk("clear2 ready", Ready, 0);
        WrEn = 1; WrAddr = 2; WrData = 10'h2F2; RdEn = 1; RdAddr = 2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("init req ignored %0d", i), RdValid, 0);
        end
        idle_a();
        Reset = 1;
        step();
        Reset = 0;
        chk("midsweep reset ready", Ready, 0);
        chk("midsweep reset rdvalid", RdValid, 0);
        count_init(16, "midsweep init len");
        RdEn = 1; RdAddr = 2;
        step();
        RdEn = 0;
        chk("init write dropped hit", Hit, 0);
        chk("init write dropped tgt", Target, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
